// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI channel-voice message parser.
// Covers the parser states, status nibbles and the note event record.
package midi_pkg;

    typedef enum logic [1:0] {
        WAIT_STATUS = 2'd0,
        WAIT_D1     = 2'd1,
        WAIT_D2     = 2'd2
    } parser_state_t;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;

    typedef struct packed {
        logic       note_on;
        logic [3:0] channel;
        logic [6:0] note;
        logic [6:0] velocity;
    } note_event_t;

    // Program change and channel pressure carry a single data byte.
    function automatic logic single_data_msg(input logic [3:0] nibble);
        return (nibble == PROG_CHG) || (nibble == CHAN_PRESS);
    endfunction

    function automatic logic is_realtime(input logic [7:0] b);
        return b >= 8'hF8;
    endfunction

    function automatic logic is_system_common(input logic [7:0] b);
        return (b[7:4] == 4'hF) && (b < 8'hF8);
    endfunction

endpackage

// File: rtl/midi_byte_strobe.sv
// Turns the decoder's valid level into a one-cycle byte strobe and
// keeps a copy of the byte delivered by the most recent strobe.
module midi_byte_strobe (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       strobe,
    output logic [7:0] byte_data
);

    logic       byte_valid_q;
    logic [7:0] byte_q;

    // byte_valid_q resets high so a level already asserted at reset release
    // is not mistaken for a fresh byte.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            byte_valid_q <= 1'b1;
            byte_q       <= 8'h00;
        end else begin
            byte_valid_q <= byte_valid;
            if (strobe) begin
                byte_q <= byte_in;
            end
        end
    end

    assign strobe    = byte_valid & ~byte_valid_q;
    assign byte_data = strobe ? byte_in : byte_q;

endmodule

// File: rtl/midi_message_parser.sv
// Parses a MIDI byte stream into note-on/note-off events with running status,
// a single-entry output slot with valid/ready handshake and a saturating drop counter.
module midi_message_parser
    import midi_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter int          DROP_CNT_W   = 8
) (
    input  logic                  clk_100mhz,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic                  evt_note_on,
    output logic [3:0]            evt_channel,
    output logic [6:0]            evt_note,
    output logic [6:0]            evt_velocity,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic        strobe;
    logic [7:0]  byte_data;

    parser_state_t         state, state_n;
    logic [7:0]            run_status, run_status_n;
    logic [6:0]            d1, d1_n;
    note_event_t           evt_q, evt_n, new_evt;
    logic                  evt_valid_q, evt_valid_n;
    logic [DROP_CNT_W-1:0] drop_q, drop_n;
    logic                  evt_fire;
    logic                  handshake;
    logic [3:0]            status_nibble;
    logic [6:0]            d2;

    midi_byte_strobe u_byte_strobe (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .strobe     (strobe),
        .byte_data  (byte_data)
    );

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state       <= WAIT_STATUS;
            run_status  <= 8'h00;
            d1          <= 7'h00;
            evt_q       <= '0;
            evt_valid_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state       <= state_n;
            run_status  <= run_status_n;
            d1          <= d1_n;
            evt_q       <= evt_n;
            evt_valid_q <= evt_valid_n;
            drop_q      <= drop_n;
        end
    end

    assign status_nibble = run_status[7:4];
    assign d2            = byte_data[6:0];
    assign handshake     = evt_valid_q & evt_ready;

    always_comb begin
        state_n      = state;
        run_status_n = run_status;
        d1_n         = d1;
        evt_fire     = 1'b0;
        new_evt      = '0;

        if (strobe) begin
            if (is_realtime(byte_data)) begin
                state_n = state;
            end else if (is_system_common(byte_data)) begin
                state_n      = WAIT_STATUS;
                run_status_n = 8'h00;
            end else if (byte_data[7]) begin
                state_n      = WAIT_D1;
                run_status_n = byte_data;
            end else begin
                case (state)
                    WAIT_STATUS: begin
                        state_n = WAIT_STATUS;
                    end
                    WAIT_D1: begin
                        d1_n    = byte_data[6:0];
                        state_n = single_data_msg(status_nibble) ? WAIT_D1 : WAIT_D2;
                    end
                    WAIT_D2: begin
                        state_n          = WAIT_D1;
                        new_evt.channel  = run_status[3:0];
                        new_evt.note     = d1;
                        new_evt.note_on  = (status_nibble == NOTE_ON) && (d2 != 7'd0);
                        new_evt.velocity = new_evt.note_on ? d2 : 7'd0;
                        // Masked channels vanish here so they never reach the drop logic.
                        if ((status_nibble == NOTE_ON) || (status_nibble == NOTE_OFF)) begin
                            evt_fire = CHANNEL_MASK[run_status[3:0]];
                        end
                    end
                    default: begin
                        state_n = WAIT_STATUS;
                    end
                endcase
            end
        end
    end

    // A slot being handed off this cycle counts as free for the new event.
    always_comb begin
        evt_n       = evt_q;
        evt_valid_n = evt_valid_q;
        drop_n      = drop_q;

        if (evt_fire) begin
            if (!evt_valid_q || handshake) begin
                evt_n       = new_evt;
                evt_valid_n = 1'b1;
            end else if (drop_q != {DROP_CNT_W{1'b1}}) begin
                drop_n = drop_q + DROP_CNT_W'(1);
            end
        end else if (handshake) begin
            evt_valid_n = 1'b0;
        end
    end

    assign evt_valid    = evt_valid_q;
    assign evt_note_on  = evt_q.note_on;
    assign evt_channel  = evt_q.channel;
    assign evt_note     = evt_q.note;
    assign evt_velocity = evt_q.velocity;
    assign drop_count   = drop_q;

endmodule
